// File: rtl/adder_test_pkg.sv
// Shared widths, constants and types for the adder test bench blocks.
package adder_test_pkg;
  localparam int OP_W  = 16;
  localparam int SUM_W = 17;

  // MISR feedback taps at bits 15, 14, 13 and 4
  localparam logic [OP_W-1:0] MISR_TAPS  = 16'hE010;
  localparam logic [OP_W-1:0] MISR_SEED  = 16'h0001;
  localparam logic [OP_W-1:0] NO_ERR_IDX = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic            vld;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic [OP_W-1:0] idx;
  } dline_t;
endpackage

// File: rtl/adder_misr.sv
// 16-bit MISR compacting a 17-bit result; the carry folds into the top bit.
module adder_misr import adder_test_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SUM_W-1:0] din,
  output logic [OP_W-1:0]  sig
);
  logic fb;
  assign fb = ^(sig & MISR_TAPS);

  always_ff @(posedge clk) begin
    if (rst)     sig <= MISR_SEED;
    else if (en) sig <= {sig[OP_W-2:0], fb} ^ din[OP_W-1:0] ^ {din[OP_W], {(OP_W-1){1'b0}}};
  end
endmodule

// File: rtl/adder_ora.sv
// Output response analyzer: aligns captured operands to the adder latency,
// checks each result against a reference sum and compacts results in a MISR.
module adder_ora import adder_test_pkg::*; #(
  parameter int PATTERNS    = 100,
  parameter int DUT_LATENCY = 1,
  parameter int START_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic [SUM_W-1:0] sum,
  output logic             done,
  output logic             pass,
  output logic [OP_W-1:0]  err_count,
  output logic [OP_W-1:0]  first_err_idx,
  output logic [OP_W-1:0]  signature
);
  state_t           state;
  logic [3:0]       dly_cnt, drn_cnt;
  logic [OP_W-1:0]  cap_cnt;
  logic             cap, cmp_vld, mism, fin;
  logic [OP_W-1:0]  cmp_a, cmp_b, cmp_idx, err_next;
  logic [SUM_W-1:0] expect_sum;

  // The final IDLE edge already captures pattern 0, so START_DELAY=0 captures on cycle 1.
  assign cap = (state == RUN) || (state == IDLE && dly_cnt == 4'(START_DELAY));

  if (DUT_LATENCY == 0) begin : g_bypass
    assign cmp_vld = cap;
    assign cmp_a   = a;
    assign cmp_b   = b;
    assign cmp_idx = cap_cnt;
  end else begin : g_dline
    dline_t pipe [DUT_LATENCY];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DUT_LATENCY; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= '{vld: cap, a: a, b: b, idx: cap_cnt};
        for (int i = 1; i < DUT_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign cmp_vld = pipe[DUT_LATENCY-1].vld && (state != DONE);
    assign cmp_a   = pipe[DUT_LATENCY-1].a;
    assign cmp_b   = pipe[DUT_LATENCY-1].b;
    assign cmp_idx = pipe[DUT_LATENCY-1].idx;
  end

  assign expect_sum = {1'b0, cmp_a} + {1'b0, cmp_b};
  assign mism       = cmp_vld && (sum != expect_sum);
  assign err_next   = (mism && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
  // Last compare edge: the final capture itself when unpipelined, else the end of DRAIN.
  assign fin = (DUT_LATENCY == 0) ? (cap && cap_cnt == 16'(PATTERNS-1))
                                  : (state == DRAIN && drn_cnt == 4'(DUT_LATENCY-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dly_cnt       <= '0;
      drn_cnt       <= '0;
      cap_cnt       <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= NO_ERR_IDX;
    end else if (state != DONE) begin
      if (cmp_vld) begin
        err_count <= err_next;
        if (mism && first_err_idx == NO_ERR_IDX) first_err_idx <= cmp_idx;
      end
      if (cap) begin
        cap_cnt <= cap_cnt + 16'd1;
        state   <= (cap_cnt == 16'(PATTERNS-1)) ? DRAIN : RUN;
      end else if (state == IDLE) begin
        dly_cnt <= dly_cnt + 4'd1;
      end
      if (state == DRAIN) drn_cnt <= drn_cnt + 4'd1;
      if (fin) begin
        state <= DONE;
        done  <= 1'b1;
        pass  <= (err_next == '0);
      end
    end
  end

  adder_misr u_misr (
    .clk (clk),
    .rst (rst),
    .en  (cmp_vld),
    .din (sum),
    .sig (signature)
  );
endmodule

// File: tb/tb_adder_ora.sv
// Self-checking bench: four analyzer instances with different latency/delay
// settings, fed by a behavioural adder model with optional result corruption.
module tb_adder_ora;
  localparam int ND   = 4;
  localparam int MAXP = 16;
  localparam int NPV [ND] = '{4, 1, 8, 8};
  localparam int LTV [ND] = '{1, 0, 3, 0};
  localparam int SDV [ND] = '{1, 0, 2, 3};

  typedef struct packed {
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [3:0][16:0] xm;
    logic [15:0]      exp_err;
    logic [15:0]      exp_first;
    logic             exp_pass;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a [ND];
  logic [15:0] b [ND];
  logic [16:0] sum [ND];
  logic        done [ND];
  logic        pass [ND];
  logic [15:0] err_count [ND];
  logic [15:0] first_err_idx [ND];
  logic [15:0] signature [ND];

  logic [15:0] pa [ND][MAXP];
  logic [15:0] pb [ND][MAXP];
  logic [16:0] ps [ND][MAXP];
  int          dlat [ND];
  int          cyc, checks, failures;
  vec_t        tbl [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    adder_ora #(.PATTERNS(NPV[g]), .DUT_LATENCY(LTV[g]), .START_DELAY(SDV[g])) u_dut (
      .clk           (clk),
      .rst           (rst),
      .a             (a[g]),
      .b             (b[g]),
      .sum           (sum[g]),
      .done          (done[g]),
      .pass          (pass[g]),
      .err_count     (err_count[g]),
      .first_err_idx (first_err_idx[g]),
      .signature     (signature[g])
    );
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
    end
  endtask

  // Drive the values seen at the upcoming edge (cycle cyc+1), then clock it.
  task automatic step();
    for (int d = 0; d < ND; d++) begin
      int k = cyc - SDV[d];
      int j = cyc - SDV[d] - dlat[d];
      if (k >= 0 && k < NPV[d]) begin
        a[d] = pa[d][k]; b[d] = pb[d][k];
      end else begin
        a[d] = 16'($urandom); b[d] = 16'($urandom);
      end
      if (j >= 0 && j < NPV[d]) sum[d] = ps[d][j];
      else                      sum[d] = 17'($urandom);
    end
    @(posedge clk); #1;
    if (!rst) cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic fill_rand(input int d, input bit faults);
    for (int k = 0; k < MAXP; k++) begin
      pa[d][k] = 16'($urandom);
      pb[d][k] = 16'($urandom);
      ps[d][k] = {1'b0, pa[d][k]} + {1'b0, pb[d][k]};
      if (faults && $urandom_range(0, 3) == 0) ps[d][k] ^= 17'(1) << $urandom_range(0, 16);
    end
  endtask

  task automatic check_final(input int d);
    int          nerr  = 0;
    logic [15:0] first = 16'hFFFF;
    logic [15:0] s     = 16'h0001;
    if (dlat[d] != LTV[d]) begin
      chk("wrong_lat_err", d, 32'(err_count[d] != 0), 32'd1);
      chk("wrong_lat_pass", d, 32'(pass[d]), 32'd0);
      return;
    end
    for (int k = 0; k < NPV[d]; k++) begin
      if (ps[d][k] != {1'b0, pa[d][k]} + {1'b0, pb[d][k]}) begin
        if (nerr == 0) first = 16'(k);
        nerr++;
      end
      s = {s[14:0], s[15] ^ s[14] ^ s[13] ^ s[4]} ^ ps[d][k][15:0] ^ {ps[d][k][16], 15'b0};
    end
    chk("err_count", d, 32'(err_count[d]), 32'(nerr));
    chk("first_err_idx", d, 32'(first_err_idx[d]), 32'(first));
    chk("signature", d, 32'(signature[d]), 32'(s));
    chk("pass", d, 32'(pass[d]), 32'(nerr == 0));
  endtask

  task automatic run_all(input bit with_reset);
    int cmax = 0;
    if (with_reset) do_reset();
    for (int d = 0; d < ND; d++)
      if (SDV[d] + NPV[d] + LTV[d] > cmax) cmax = SDV[d] + NPV[d] + LTV[d];
    while (cyc < cmax + 2) begin
      step();
      for (int d = 0; d < ND; d++) begin
        int c = SDV[d] + NPV[d] + LTV[d];
        if (cyc == c - 1) chk("done_early", d, 32'(done[d]), 32'd0);
        if (cyc == c) begin
          chk("done", d, 32'(done[d]), 32'd1);
          check_final(d);
        end
        if (cyc == cmax + 2) begin
          chk("done_hold", d, 32'(done[d]), 32'd1);
          check_final(d);
        end
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    for (int d = 0; d < ND; d++) begin
      dlat[d] = LTV[d];
      a[d] = '0; b[d] = '0; sum[d] = '0;
    end

    tbl[0] = '{a: {16'h0004, 16'hFFFF, 16'h8000, 16'h0001},
               b: {16'h0003, 16'hFFFF, 16'h8000, 16'h0000},
               xm: '0, exp_err: 16'd0, exp_first: 16'hFFFF, exp_pass: 1'b1};
    tbl[1] = '{a: {16'h0010, 16'hFFFF, 16'h0ABC, 16'h0001},
               b: {16'h0020, 16'h0001, 16'h0DEF, 16'h0002},
               xm: {17'h0, 17'h10000, 17'h0, 17'h0},
               exp_err: 16'd1, exp_first: 16'd2, exp_pass: 1'b0};
    tbl[2] = '{a: {16'h1111, 16'h2222, 16'h3333, 16'h4444},
               b: {16'h5555, 16'h6666, 16'h7777, 16'h8888},
               xm: {17'h1, 17'h0, 17'h1, 17'h0},
               exp_err: 16'd2, exp_first: 16'd1, exp_pass: 1'b0};

    // Reset state
    rst = 1'b1; step(); step();
    for (int d = 0; d < ND; d++) begin
      chk("rst_done", d, 32'(done[d]), 32'd0);
      chk("rst_first", d, 32'(first_err_idx[d]), 32'hFFFF);
      chk("rst_sig", d, 32'(signature[d]), 32'h0001);
    end

    // Table vectors on the 4-pattern instance; random traffic elsewhere.
    for (int i = 0; i < 3; i++) begin
      for (int d = 1; d < ND; d++) fill_rand(d, i != 0);
      for (int k = 0; k < 4; k++) begin
        pa[0][k] = tbl[i].a[k];
        pb[0][k] = tbl[i].b[k];
        ps[0][k] = ({1'b0, tbl[i].a[k]} + {1'b0, tbl[i].b[k]}) ^ tbl[i].xm[k];
      end
      if (i == 0) begin
        pa[1][0] = '0; pb[1][0] = '0; ps[1][0] = '0;
      end
      run_all(1'b1);
      chk("tbl_err", 0, 32'(err_count[0]), 32'(tbl[i].exp_err));
      chk("tbl_first", 0, 32'(first_err_idx[0]), 32'(tbl[i].exp_first));
      chk("tbl_pass", 0, 32'(pass[0]), 32'(tbl[i].exp_pass));
      if (i == 0) begin
        chk("seed_sig", 1, 32'(signature[1]), 32'h0002);
        chk("seed_pass", 1, 32'(pass[1]), 32'd1);
      end
    end

    // Adder model one cycle too fast for the latency-3 analyzer.
    for (int d = 0; d < ND; d++) fill_rand(d, 1'b0);
    dlat[2] = 2;
    run_all(1'b1);
    dlat[2] = LTV[2];

    // Reset mid-run after an injected error, then a clean full rerun.
    for (int d = 0; d < ND; d++) fill_rand(d, 1'b0);
    ps[0][0] ^= 17'h1;
    do_reset();
    while (cyc < 3) step();
    chk("mid_err", 0, 32'(err_count[0]), 32'd1);
    rst = 1'b1; step(); rst = 1'b0; cyc = 0;
    for (int d = 0; d < ND; d++) begin
      chk("mid_rst_done", d, 32'(done[d]), 32'd0);
      chk("mid_rst_pass", d, 32'(pass[d]), 32'd0);
      chk("mid_rst_err", d, 32'(err_count[d]), 32'd0);
      chk("mid_rst_first", d, 32'(first_err_idx[d]), 32'hFFFF);
      chk("mid_rst_sig", d, 32'(signature[d]), 32'h0001);
    end
    ps[0][0] ^= 17'h1;
    run_all(1'b0);
    for (int d = 0; d < ND; d++) chk("rerun_pass", d, 32'(pass[d]), 32'd1);

    // Randomized data with random result corruption.
    for (int r = 0; r < 6; r++) begin
      for (int d = 0; d < ND; d++) fill_rand(d, 1'b1);
      run_all(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_ora.md
# adder_ora

Output response analyzer for the adder test bench. Sits directly downstream of the pattern generator and the adder under test: samples the same `a`/`b` operands the generator drives, aligns them to the adder's result latency, and checks every result against a reference sum. Also compacts the results into a 16-bit MISR signature. After a fixed pattern count it raises `done` with pass/fail, error count, first failing index and signature.

## Interface
- `PATTERNS`, 100: number of operand pairs captured and checked; 1..65535.
- `DUT_LATENCY`, 1: posedges from operands sampled to matching `sum` sampled; 0..8.
- `START_DELAY`, 1: posedges after reset release that are ignored before capture starts; 0..15.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `a` in 16: operand A from the pattern generator.
- `b` in 16: operand B from the pattern generator.
- `sum` in 17: adder result, `{carry_out, sum[15:0]}`.
- `done` out 1: checking complete; held until reset.
- `pass` out 1: `done` and zero errors.
- `err_count` out 16: mismatches seen; saturates at 16'hFFFF.
- `first_err_idx` out 16: pattern index of first mismatch; 16'hFFFF if none.
- `signature` out 16: MISR state.

## Operation
- Reset values, applied on any posedge with `rst`=1:
  - state IDLE
  - `done`=0, `pass`=0, `err_count`=0, `first_err_idx`=16'hFFFF, `signature`=16'h0001
  - delay line and valid bits cleared
  - capture and compare counters 0
- FSM states:
  - IDLE: counts START_DELAY posedges, then goes to RUN. If START_DELAY=0, goes to RUN on the first posedge.
  - RUN: captures `a`,`b` every posedge into the delay line with valid=1 and index k, for k=0..PATTERNS-1. After the last capture, goes to DRAIN, or to DONE if DUT_LATENCY=0.
  - DRAIN: no capture; continues comparing for DUT_LATENCY posedges, then goes to DONE.
  - DONE: all outputs frozen. Only reset leaves DONE.
- Check: on each posedge where the delayed valid=1:
  - expected = delayed `a` + delayed `b`, computed as a zero-extended 17-bit sum.
  - mismatch when `sum` != expected, across all 17 bits.
  - on mismatch, `err_count` increments with saturation. `first_err_idx` takes the delayed index only if it is still 16'hFFFF.
- DUT_LATENCY=0: the current `a`,`b` are compared against the current `sum` in the capture cycle itself.
- MISR update, on every compare cycle only:
  - fb = sig[15]^sig[14]^sig[13]^sig[4]
  - sig_next = {sig[14:0],fb} ^ `sum[15:0]` ^ {`sum[16]`,15'b0}
- `pass` = `done` && `err_count`==0. It is registered and asserted on the same edge as `done`.
- Each pattern is compared exactly once, including the final DUT_LATENCY patterns still in flight at the RUN→DRAIN transition.
- Inputs are ignored outside compare cycles.
- Reset mid-operation, in any state: full return to the reset values above. No partial results are retained.

## Timing
- Cycle n = the nth posedge with `rst`=0, where n starts at 1.
- Capture of pattern k happens at cycle START_DELAY+1+k.
- Compare of pattern k happens at cycle START_DELAY+1+k+DUT_LATENCY.
- Last compare happens at cycle C = START_DELAY+PATTERNS+DUT_LATENCY. `done`/`pass` become 1 at that edge, so they are visible during cycle C+1.
- Error outputs and `signature` are registered and update at the compare edge.
- No combinational path from any input to any output.

## Structure
- Package `adder_test_pkg`, holding:
  - `OP_W`=16, `SUM_W`=17
  - MISR tap constant (bits 15,14,13,4)
  - `MISR_SEED`=16'h0001
  - `NO_ERR_IDX`=16'hFFFF
  - FSM state enum {IDLE, RUN, DRAIN, DONE}
- Sub-module `adder_misr`: 16-bit MISR with `clk`, `rst`, `en`, `din[16:0]` and `sig[15:0]` ports. It is the natural reusable piece.
- Delay line: DUT_LATENCY-deep register array of {valid, a, b, idx}. It is generate-bypassed when DUT_LATENCY=0.

## Test plan
- **Correct model, clean run.** PATTERNS=4, DUT_LATENCY=1, START_DELAY=1, ideal 1-cycle adder model.
  - `done` rises at the cycle-6 edge.
  - `pass`=1, `err_count`=0, `first_err_idx`=16'hFFFF.
- **Signature seed case.** PATTERNS=1, DUT_LATENCY=0, START_DELAY=0, with a=b=0 and sum=0.
  - `signature`=16'h0002, `pass`=1.
- **Carry-out fault.** Pattern 2 has a=16'hFFFF, b=16'h0001; the model drives sum=17'h00000 instead of 17'h10000.
  - `err_count`=1, `first_err_idx`=2, `pass`=0.
- **Multiple faults.** Model corrupts sum bit 0 on patterns 1 and 3.
  - `err_count`=2, `first_err_idx`=1.
- **Latency sweep.** DUT_LATENCY=0 and 3, each with a matching model.
  - All patterns checked, `done` at cycle C, `pass`=1.
  - With DUT_LATENCY=3, a model of the wrong latency (2) gives `err_count`>0.
- **Reset mid-run.** Assert `rst` for 1 cycle during RUN after an injected error.
  - All outputs return to their reset values, then the full sequence reruns.
  - Final `pass`=1 when no fault is injected after the reset.
